mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory-access pipeline stage directly upstream of the 256x32 data memory.
- Accepts one operation at a time from execute: pass-through, word/byte load, or word/byte store.
- Drives the memory's ad/di/we/re/byte_l/byte_s pins and captures its negedge read data.
- Presents one writeback result per accepted non-store operation, with valid/ready backpressure.

Parameters:
- ADDR_BITS, 10, byte-address bits actually decoded by the data memory (256 words); any set bit in in_addr[31:ADDR_BITS] is a range fault.
- RD_BITS, 5, destination register index width.

Ports:
- clk  in  1  clock; every register in this block updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream operation valid.
- in_ready  out  1  stage can accept an operation; high only in IDLE.
- in_op  in  2  operation: 00 pass, 01 load, 10 store, 11 reserved.
- in_byte  in  1  byte-sized access (load/store only).
- in_addr  in  32  byte address (load/store) or ignored (pass).
- in_wdata  in  32  store data, or the result value for pass.
- in_rd  in  RD_BITS  destination register.
- mem_ad  out  32  to memory ad.
- mem_di  out  32  to memory di.
- mem_we  out  1  to memory we.
- mem_re  out  1  to memory re.
- mem_byte_l  out  1  to memory byte_l.
- mem_byte_s  out  1  to memory byte_s.
- mem_do  in  32  from memory d_o; valid after the negedge inside the LOAD cycle.
- wb_valid  out  1  writeback result valid.
- wb_ready  in  1  downstream accepts the result.
- wb_we  out  1  register-file write request; 0 when in_rd==0 or on a fault.
- wb_rd  out  RD_BITS  destination register.
- wb_data  out  32  result data.
- wb_err  out  1  access fault flag (no memory access was made).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All mem_* outputs and all wb_* outputs are 0; in_ready=1 after reset releases.
  - Reset during STORE drops mem_we immediately; the write is not guaranteed.
  - Memory contents are not touched by this block.
- States: IDLE, LOAD, STORE, RESP.
- IDLE, on posedge with in_valid and in_ready (accept edge k):
  - Latch the operation and compute fault = (op==11) | (|in_addr[31:ADDR_BITS]) | align fault (see Optional Feature).
  - fault: go to RESP with wb_err=1, wb_we=0, wb_data=0. No mem strobes.
  - pass: go to RESP with wb_data=in_wdata.
  - load: set mem_ad=in_addr, mem_re=1, mem_byte_l=in_byte; go to LOAD.
  - store: set mem_ad=in_addr, mem_di=in_wdata, mem_we=1, mem_byte_s=in_byte; go to STORE.
- LOAD, edge k+1:
  - wb_data=mem_do. It is passed through unmodified: the memory already zero-extends byte loads.
  - Clear mem_re and mem_byte_l; go to RESP.
- STORE, edge k+1:
  - The memory performs its write on this edge.
  - Clear mem_we and mem_byte_s; go to IDLE. Stores produce no writeback.
- RESP:
  - wb_valid=1; wb_rd, wb_data, wb_we and wb_err are held stable.
  - On posedge with wb_ready: clear wb_valid and go to IDLE.
- wb_we = (rd != 0) & ~fault.
- mem_ad and mem_di hold their last value when idle; only the strobes return to 0.
- Latencies:
  - accept→wb_valid: pass/fault 1 cycle, load 2 cycles.
  - Store occupancy: 2 cycles.
- No new accept while in RESP. Peak throughput is 1 op per 2 cycles.
- in_valid while in_ready=0 has no effect; upstream holds its operation until accepted.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: a word load/store with in_addr[1:0] != 0 is a fault. wb_err=1, no memory strobe, and wb_data=0 for loads.
- Undefined: in_addr[1:0] is ignored. The access goes to word in_addr[9:2] exactly as the memory decodes it, and only range/reserved faults exist.
- Byte accesses never align-fault. The memory always uses byte lane [7:0] regardless of in_addr[1:0].

Decomposition:
- Shared package mem_stage_pkg holds:
  - op encodings OP_PASS/OP_LOAD/OP_STORE/OP_RSVD;
  - state enum;
  - MEM_WORDS=256 and ADDR_BITS default.
- One combinational sub-module, mem_addr_check: takes op, byte and addr and returns fault. It holds the MEM_ALIGN_CHECK_EN conditional.
- The FSM and registers stay in mem_access_stage.

Test Plan:
- Store word then load: store addr=0x10 data=0xDEADBEEF; load rd=3 addr=0x10 → wb_valid 2 cycles after accept, wb_data=0xDEADBEEF, wb_rd=3, wb_we=1.
- Byte store then byte load: store byte addr=0x10 data=0x000000A5, then byte load addr=0x10 → wb_data=0x000000A5. A subsequent word load gives 0xDEADBEA5.
- Pass-through with backpressure: pass rd=0 data=0x1234 with wb_ready=0 for 3 cycles → wb_valid held, data stable, wb_we=0, in_ready=0 throughout. Returns to IDLE after the wb_ready edge.
- Faults:
  - load addr=0x400 → wb_err=1, mem_re never asserted.
  - With MEM_ALIGN_CHECK_EN, word load addr=0x12 → wb_err=1.
  - Without it, the same load returns word 4's contents.
- Reset mid-store: assert rst_n=0 while in STORE → mem_we=0 immediately, all wb_* outputs 0; after release in_ready=1 and a new load is accepted normally.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage.
// Holds the operation encodings, the stage FSM state type and the data
// memory geometry. Imported by mem_addr_check and mem_access_stage.
package mem_stage_pkg;

  // Data memory geometry: 256 words of 32 bits, byte addressed.
  localparam int MEM_WORDS     = 256;
  localparam int MEM_ADDR_BITS = 10;

  typedef enum logic [1:0] {
    OP_PASS  = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_RSVD  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_STORE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// Bundle of all non-clock signals of the memory-access stage.
//   in_*  : operation from execute (valid/ready)
//   mem_* : pins of the 256x32 data memory
//   wb_*  : writeback result (valid/ready)
// Modports:
//   slave  - the stage itself
//   master - the surrounding environment (execute, memory, writeback)
//
// Handshake rule for both in_* and wb_*: a transfer happens on the rising
// clock edge where valid and ready are both 1. A producer holds valid and its
// payload stable until that edge; ready may change freely.
interface mem_access_stage_if #(
  parameter int RD_BITS = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_op;
  logic               in_byte;
  logic [31:0]        in_addr;
  logic [31:0]        in_wdata;
  logic [RD_BITS-1:0] in_rd;

  logic [31:0]        mem_ad;
  logic [31:0]        mem_di;
  logic               mem_we;
  logic               mem_re;
  logic               mem_byte_l;
  logic               mem_byte_s;
  logic [31:0]        mem_do;

  logic               wb_valid;
  logic               wb_ready;
  logic               wb_we;
  logic [RD_BITS-1:0] wb_rd;
  logic [31:0]        wb_data;
  logic               wb_err;

  modport slave (
    input  in_valid, in_op, in_byte, in_addr, in_wdata, in_rd,
    output in_ready,
    output mem_ad, mem_di, mem_we, mem_re, mem_byte_l, mem_byte_s,
    input  mem_do,
    output wb_valid, wb_we, wb_rd, wb_data, wb_err,
    input  wb_ready
  );

  modport master (
    output in_valid, in_op, in_byte, in_addr, in_wdata, in_rd,
    input  in_ready,
    input  mem_ad, mem_di, mem_we, mem_re, mem_byte_l, mem_byte_s,
    output mem_do,
    input  wb_valid, wb_we, wb_rd, wb_data, wb_err,
    output wb_ready
  );
endinterface

// File: rtl/mem_addr_check.sv
// Combinational access-fault decode for one incoming operation.
// Ports:
//   op      in  operation code
//   byte_sz in  byte-sized access
//   addr    in  byte address
//   fault   out operation must not touch memory and reports wb_err
// Build option: MEM_ALIGN_CHECK_EN adds a fault for word loads/stores whose
// address is not word aligned. Without it the low two address bits are
// ignored, matching how the memory itself decodes the word index.
module mem_addr_check
  import mem_stage_pkg::*;
#(
  parameter int ADDR_BITS = MEM_ADDR_BITS
) (
  input  op_t         op,
  input  logic        byte_sz,
  input  logic [31:0] addr,
  output logic        fault
);

  logic mem_op;
  logic range_fault;
  logic align_fault;

  assign mem_op = (op == OP_LOAD) || (op == OP_STORE);

  // Pass ignores its address, so the range test only applies to real accesses.
  assign range_fault = mem_op && ((addr >> ADDR_BITS) != 32'd0);

`ifdef MEM_ALIGN_CHECK_EN
  assign align_fault = mem_op && !byte_sz && (addr[1:0] != 2'b00);
`else
  logic unused_align;
  assign unused_align = byte_sz;
  assign align_fault  = 1'b0;
`endif

  assign fault = (op == OP_RSVD) || range_fault || align_fault;

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage in front of the 256x32 data memory.
// Takes one operation at a time from execute (pass, load, store; word or
// byte), drives the memory pins, captures read data from the memory's
// negedge output and presents one writeback result per non-store operation.
// Ports:
//   clk       in  clock, all registers update on posedge
//   rst_n     in  asynchronous active-low reset
//   bus       --  mem_access_stage_if.slave (in_*, mem_*, wb_* signals)
//   dbg_state out current FSM state, for observation only
// Build option: MEM_ALIGN_CHECK_EN (see mem_addr_check).
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_BITS = MEM_ADDR_BITS,
  parameter int RD_BITS   = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_access_stage_if.slave   bus,
  output state_t              dbg_state
);

  state_t state;
  op_t    op;
  logic   fault;
  logic   rd_nonzero;

  assign op         = op_t'(bus.in_op);
  assign rd_nonzero = (bus.in_rd != {RD_BITS{1'b0}});
  assign dbg_state  = state;

  // Accept only from IDLE; this is what limits throughput to one op per two cycles.
  assign bus.in_ready = (state == S_IDLE);

  mem_addr_check #(
    .ADDR_BITS (ADDR_BITS)
  ) u_check (
    .op      (op),
    .byte_sz (bus.in_byte),
    .addr    (bus.in_addr),
    .fault   (fault)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      bus.mem_ad     <= '0;
      bus.mem_di     <= '0;
      bus.mem_we     <= 1'b0;
      bus.mem_re     <= 1'b0;
      bus.mem_byte_l <= 1'b0;
      bus.mem_byte_s <= 1'b0;
      bus.wb_valid   <= 1'b0;
      bus.wb_we      <= 1'b0;
      bus.wb_rd      <= '0;
      bus.wb_data    <= '0;
      bus.wb_err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            if (fault) begin
              bus.wb_valid <= 1'b1;
              bus.wb_err   <= 1'b1;
              bus.wb_we    <= 1'b0;
              bus.wb_rd    <= bus.in_rd;
              bus.wb_data  <= '0;
              state        <= S_RESP;
            end else begin
              case (op)
                OP_LOAD: begin
                  bus.mem_ad     <= bus.in_addr;
                  bus.mem_re     <= 1'b1;
                  bus.mem_byte_l <= bus.in_byte;
                  bus.wb_err     <= 1'b0;
                  bus.wb_we      <= rd_nonzero;
                  bus.wb_rd      <= bus.in_rd;
                  state          <= S_LOAD;
                end
                OP_STORE: begin
                  bus.mem_ad     <= bus.in_addr;
                  bus.mem_di     <= bus.in_wdata;
                  bus.mem_we     <= 1'b1;
                  bus.mem_byte_s <= bus.in_byte;
                  state          <= S_STORE;
                end
                default: begin
                  // OP_PASS; OP_RSVD never gets here because it always faults.
                  bus.wb_valid <= 1'b1;
                  bus.wb_err   <= 1'b0;
                  bus.wb_we    <= rd_nonzero;
                  bus.wb_rd    <= bus.in_rd;
                  bus.wb_data  <= bus.in_wdata;
                  state        <= S_RESP;
                end
              endcase
            end
          end
        end
        S_LOAD: begin
          // mem_do settled on the preceding negedge; byte loads are already
          // zero-extended by the memory.
          bus.wb_data    <= bus.mem_do;
          bus.wb_valid   <= 1'b1;
          bus.mem_re     <= 1'b0;
          bus.mem_byte_l <= 1'b0;
          state          <= S_RESP;
        end
        S_STORE: begin
          // The memory writes on this edge; only the strobes are dropped,
          // address and data keep their last value.
          bus.mem_we     <= 1'b0;
          bus.mem_byte_s <= 1'b0;
          state          <= S_IDLE;
        end
        S_RESP: begin
          if (bus.wb_ready) begin
            bus.wb_valid <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
  import mem_stage_pkg::*;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_t dbg_state;

  always #5 clk = ~clk;

  mem_access_stage_if #(.RD_BITS(5)) bus ();

  mem_access_stage #(.ADDR_BITS(10), .RD_BITS(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- data memory stand-in ----------------
  // Writes on posedge, reads on negedge; byte ops use lane [7:0] only.
  logic [31:0] env_mem [256];
  int          re_cnt = 0;

  always @(posedge clk) begin
    if (bus.mem_re) re_cnt++;
    if (bus.mem_we) begin
      if (bus.mem_byte_s) env_mem[bus.mem_ad[9:2]][7:0] <= bus.mem_di[7:0];
      else                env_mem[bus.mem_ad[9:2]]      <= bus.mem_di;
    end
  end

  always @(negedge clk) begin
    if (bus.mem_re) begin
      if (bus.mem_byte_l) bus.mem_do <= {24'd0, env_mem[bus.mem_ad[9:2]][7:0]};
      else                bus.mem_do <= env_mem[bus.mem_ad[9:2]];
    end
  end

  // ---------------- reference model + scoreboard ----------------
  // Transaction-level view: memory as an array, each accepted non-store op
  // yields one expected {err, we, rd, data}.
  logic [31:0] ref_mem [256];
  logic [38:0] exp_q[$];
  logic [38:0] last_wb = '0;

  function automatic void model_accept(input logic [1:0] op, input logic bsz,
                                       input logic [31:0] addr, input logic [31:0] wdata,
                                       input logic [4:0] rd);
    logic        is_mem;
    logic        flt;
    logic [7:0]  idx;
    logic [31:0] data;
    is_mem = (op == 2'b01) || (op == 2'b10);
    flt    = (op == 2'b11) || (is_mem && addr >= 32'd1024);
`ifdef MEM_ALIGN_CHECK_EN
    if (is_mem && !bsz && (addr % 4 != 0)) flt = 1'b1;
`endif
    idx = 8'((addr % 1024) / 4);
    if (flt) begin
      exp_q.push_back({1'b1, 1'b0, rd, 32'd0});
    end else if (op == 2'b10) begin
      if (bsz) ref_mem[idx] = {ref_mem[idx][31:8], wdata[7:0]};
      else     ref_mem[idx] = wdata;
    end else begin
      if (op == 2'b01) data = bsz ? {24'd0, ref_mem[idx][7:0]} : ref_mem[idx];
      else             data = wdata;
      exp_q.push_back({1'b0, rd != 5'd0, rd, data});
    end
  endfunction

  // Compare process: every cycle a result is presented it must match the
  // head of the expected queue; it leaves the queue on the handshake.
  always @(negedge clk) begin
    if (rst_n && bus.wb_valid) begin
      check("in_ready_in_resp", {63'd0, bus.in_ready}, 64'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_wb actual=%h expected=none", bus.wb_data);
      end else begin
        check("wb_result", {25'd0, bus.wb_err, bus.wb_we, bus.wb_rd, bus.wb_data},
              {25'd0, exp_q[0]});
        if (bus.wb_ready) begin
          last_wb = {bus.wb_err, bus.wb_we, bus.wb_rd, bus.wb_data};
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // exp_lat: cycles from accept to wb_valid; 0 = store (check occupancy);
  // -1 = return right after the accept edge without further checks.
  task automatic issue(input logic [1:0] op, input logic bsz, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd, input int exp_lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", {63'd0, bus.in_ready}, 64'd1);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_byte  = bsz;
    bus.in_addr  = addr;
    bus.in_wdata = wdata;
    bus.in_rd    = rd;
    model_accept(op, bsz, addr, wdata, rd);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (exp_lat > 0) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!bus.wb_valid && n < 10);
      check("wb_latency", 64'(n), 64'(exp_lat));
    end else if (exp_lat == 0) begin
      @(negedge clk);
      check("store_we_on", {63'd0, bus.mem_we}, 64'd1);
      check("store_busy", {63'd0, bus.in_ready}, 64'd0);
      @(negedge clk);
      check("store_we_off", {63'd0, bus.mem_we}, 64'd0);
      check("store_done_ready", {63'd0, bus.in_ready}, 64'd1);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", {63'd0, bus.in_ready}, 64'd1);
  endtask

  // ---------------- directed test ----------------
  int re_before;

  initial begin
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = 32'h1000_0000 + 32'(i);
      ref_mem[i] = 32'h1000_0000 + 32'(i);
    end
    bus.mem_do   = '0;
    bus.in_valid = 1'b0;
    bus.in_op    = 2'b00;
    bus.in_byte  = 1'b0;
    bus.in_addr  = '0;
    bus.in_wdata = '0;
    bus.in_rd    = '0;
    bus.wb_ready = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_mem_we", {63'd0, bus.mem_we}, 64'd0);
    check("rst_mem_re", {63'd0, bus.mem_re}, 64'd0);
    check("rst_mem_ad", {32'd0, bus.mem_ad}, 64'd0);
    check("rst_wb", {25'd0, bus.wb_valid, bus.wb_we, bus.wb_err, bus.wb_rd, bus.wb_data}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("rst_state", {62'd0, dbg_state}, {62'd0, S_IDLE});

    // store word then load it back
    issue(2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 5'd0, 0);
    issue(2'b01, 1'b0, 32'h10, 32'd0, 5'd3, 2);
    wait_idle();
    check("lit_load_word", {25'd0, last_wb}, {25'd0, 1'b0, 1'b1, 5'd3, 32'hDEAD_BEEF});

    // byte store then byte and word loads
    issue(2'b10, 1'b1, 32'h10, 32'h0000_00A5, 5'd0, 0);
    issue(2'b01, 1'b1, 32'h10, 32'd0, 5'd4, 2);
    wait_idle();
    check("lit_load_byte", {32'd0, last_wb[31:0]}, 64'h0000_00A5);
    issue(2'b01, 1'b0, 32'h10, 32'd0, 5'd5, 2);
    wait_idle();
    check("lit_load_merged", {32'd0, last_wb[31:0]}, 64'hDEAD_BEA5);

    // pass-through with backpressure, rd=0
    bus.wb_ready = 1'b0;
    issue(2'b00, 1'b0, 32'h0, 32'h0000_1234, 5'd0, 1);
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", {63'd0, bus.wb_valid}, 64'd1);
      check("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
      check("bp_data", {32'd0, bus.wb_data}, 64'h1234);
      check("bp_we", {63'd0, bus.wb_we}, 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.wb_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_ready", {63'd0, bus.in_ready}, 64'd1);
    check("bp_release_valid", {63'd0, bus.wb_valid}, 64'd0);

    // range fault: no read strobe
    re_before = re_cnt;
    issue(2'b01, 1'b0, 32'h400, 32'd0, 5'd6, 1);
    wait_idle();
    check("lit_range_err", {63'd0, last_wb[38]}, 64'd1);
    check("range_no_re", 64'(re_cnt), 64'(re_before));

    // misaligned word load
`ifdef MEM_ALIGN_CHECK_EN
    re_before = re_cnt;
    issue(2'b01, 1'b0, 32'h12, 32'd0, 5'd7, 1);
    wait_idle();
    check("lit_align_err", {25'd0, last_wb}, {25'd0, 1'b1, 1'b0, 5'd7, 32'd0});
    check("align_no_re", 64'(re_cnt), 64'(re_before));
`else
    issue(2'b01, 1'b0, 32'h12, 32'd0, 5'd7, 2);
    wait_idle();
    check("lit_unaligned_word4", {25'd0, last_wb}, {25'd0, 1'b0, 1'b1, 5'd7, 32'hDEAD_BEA5});
`endif

    // reserved op faults; plain pass with nonzero rd
    issue(2'b11, 1'b0, 32'h0, 32'h5555_5555, 5'd8, 1);
    wait_idle();
    check("lit_rsvd_err", {25'd0, last_wb}, {25'd0, 1'b1, 1'b0, 5'd8, 32'd0});
    issue(2'b00, 1'b0, 32'h0, 32'h0000_ABCD, 5'd9, 1);
    wait_idle();
    check("lit_pass", {25'd0, last_wb}, {25'd0, 1'b0, 1'b1, 5'd9, 32'h0000_ABCD});

    // reset in the middle of a store (word 8 is never read back)
    issue(2'b10, 1'b0, 32'h20, 32'hCAFE_F00D, 5'd0, -1);
    check("mid_store_we", {63'd0, bus.mem_we}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_store_we", {63'd0, bus.mem_we}, 64'd0);
    check("rst_store_wb", {25'd0, bus.wb_valid, bus.wb_we, bus.wb_err, bus.wb_rd, bus.wb_data}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {63'd0, bus.in_ready}, 64'd1);
    issue(2'b01, 1'b0, 32'h10, 32'd0, 5'd10, 2);
    wait_idle();
    check("lit_post_rst_load", {25'd0, last_wb}, {25'd0, 1'b0, 1'b1, 5'd10, 32'hDEAD_BEA5});

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
